network_output_decoder: RTL

//  Consumer end of the network's output-alignment barrier. Captures the aligned vector
//  of output-layer values on a single VALID_IN pulse and scans it serially, one element
//  per cycle, to find the winning class (argmax) and the count of positive nodes.

---
 rtl/network_output_decoder_if.sv | 29 ++
 rtl/network_output_decoder.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/network_output_decoder_if.sv
// Handshake and bus bundle for network_output_decoder.
// master: upstream/downstream environment side; slave: the decoder itself.
interface network_output_decoder_if #(
    parameter int unsigned NUM_INPUTS = 5,
    parameter int unsigned WIDTH      = 16
);
    localparam int unsigned IW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int unsigned CW = $clog2(NUM_INPUTS + 1);

    logic [NUM_INPUTS-1:0][WIDTH-1:0] values_in;
    logic                             valid_in;
    logic [IW-1:0]                    class_out;
    logic [CW-1:0]                    pos_count;
    logic                             ambiguous;
    logic                             valid_out;
    logic                             ready_in;
    logic                             overrun;
    logic [7:0]                       drop_count;

    modport master (
        output values_in, valid_in, ready_in,
        input  class_out, pos_count, ambiguous, valid_out, overrun, drop_count
    );

    modport slave (
        input  values_in, valid_in, ready_in,
        output class_out, pos_count, ambiguous, valid_out, overrun, drop_count
    );
endinterface

// File: rtl/network_output_decoder.sv
// Output-layer decoder: captures an aligned vector, scans it one element per
// cycle for argmax and positive count, and holds the result on a valid/ready
// handshake. Vectors arriving while busy are dropped and counted.
// Optional build macro DECODER_MARGIN_CHECK_EN adds runner-up tracking and the
// AMBIGUOUS flag (top1 - top2 < MARGIN_MIN); otherwise AMBIGUOUS is tied low.
module network_output_decoder #(
    parameter int unsigned     NUM_INPUTS = 5,
    parameter int unsigned     WIDTH      = 16,
    parameter int unsigned     FRAC_BITS  = 12,
    parameter logic [WIDTH-1:0] MARGIN_MIN = 16'h0800
) (
    input  logic                     clk,
    input  logic                     rst,
    network_output_decoder_if.slave  bus
);
    localparam int unsigned IW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int unsigned CW = $clog2(NUM_INPUTS + 1);

    // Elaboration-time parameter sanity
    if (NUM_INPUTS < 2) begin : g_bad_inputs
        $error("network_output_decoder: NUM_INPUTS must be >= 2");
    end
    if (FRAC_BITS >= WIDTH) begin : g_bad_frac
        $error("network_output_decoder: FRAC_BITS must be < WIDTH");
    end
    if (MARGIN_MIN[WIDTH-1]) begin : g_bad_margin
        $error("network_output_decoder: MARGIN_MIN must be non-negative");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t                           state_q, state_d;
    logic [NUM_INPUTS-1:0][WIDTH-1:0] bank_q;
    logic [IW-1:0]                    idx_q;
    logic signed [WIDTH-1:0]          max_q, max_d, elem_c;
    logic [IW-1:0]                    cls_q, cls_d;
    logic [CW-1:0]                    cnt_q, cnt_d;
    logic                             busy_c, capture_c, drop_c, handshake_c, last_c, first_c;
    logic                             amb_c;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next state, capture/drop/handshake decisions
    always_comb begin
        state_d     = state_q;
        busy_c      = (state_q != S_IDLE) && !(state_q == S_OUT && bus.ready_in);
        handshake_c = (state_q == S_OUT) && bus.ready_in;
        last_c      = (idx_q == IW'(NUM_INPUTS - 1));
        capture_c   = bus.valid_in && !busy_c;
        drop_c      = bus.valid_in && busy_c;
        case (state_q)
            S_IDLE:  if (bus.valid_in) state_d = S_SCAN;
            S_SCAN:  if (last_c) state_d = S_OUT;
            S_OUT:   if (bus.ready_in) state_d = bus.valid_in ? S_SCAN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // One scan step: strict signed compare keeps the lowest index on ties
    always_comb begin
        elem_c  = bank_q[idx_q];
        first_c = (idx_q == '0);
        max_d   = max_q;
        cls_d   = cls_q;
        cnt_d   = cnt_q + CW'(elem_c > 0);
        if (first_c) begin
            max_d = elem_c;
            cls_d = '0;
            cnt_d = CW'(elem_c > 0);
        end else if (elem_c > max_q) begin
            max_d = elem_c;
            cls_d = idx_q;
        end
    end

`ifdef DECODER_MARGIN_CHECK_EN
    logic signed [WIDTH-1:0] top2_q, top2_d;
    logic signed [WIDTH:0]   margin_c;

    // Runner-up tracking and margin compare in WIDTH+1 bits
    always_comb begin
        top2_d = top2_q;
        if (first_c)               top2_d = {1'b1, {(WIDTH-1){1'b0}}};
        else if (elem_c > max_q)   top2_d = max_q;
        else if (elem_c > top2_q)  top2_d = elem_c;
        margin_c = (WIDTH+1)'(max_d) - (WIDTH+1)'(top2_d);
        amb_c    = margin_c < (WIDTH+1)'($signed(MARGIN_MIN));
    end

    // Runner-up register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     top2_q <= '0;
        else if (state_q == S_SCAN)  top2_q <= top2_d;
    end
`else
    assign amb_c = 1'b0;
`endif

    // Capture bank, scan accumulators, result and drop bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_q         <= '0;
            idx_q          <= '0;
            max_q          <= '0;
            cls_q          <= '0;
            cnt_q          <= '0;
            bus.valid_out  <= 1'b0;
            bus.class_out  <= '0;
            bus.pos_count  <= '0;
            bus.ambiguous  <= 1'b0;
            bus.overrun    <= 1'b0;
            bus.drop_count <= '0;
        end else begin
            if (capture_c) begin
                bank_q <= bus.values_in;
                idx_q  <= '0;
            end else if (state_q == S_SCAN) begin
                idx_q <= idx_q + IW'(1);
                max_q <= max_d;
                cls_q <= cls_d;
                cnt_q <= cnt_d;
            end
            if (state_q == S_SCAN && last_c) begin
                bus.valid_out <= 1'b1;
                bus.class_out <= cls_d;
                bus.pos_count <= cnt_d;
                bus.ambiguous <= amb_c;
            end else if (handshake_c) begin
                bus.valid_out <= 1'b0;
            end
            bus.overrun <= drop_c;
            if (drop_c && bus.drop_count != 8'hFF) bus.drop_count <= bus.drop_count + 8'd1;
        end
    end
endmodule
